// File: rtl/tx_fifo_sequencer.sv
// ----------------------------------------------------------------------------
// tx_fifo_sequencer
//   Transmit-side FIFO plus launch sequencer. The host pushes words on SysClk
//   into a 2**FIFO_WIDTH deep circular buffer. A three-state sequencer hands
//   the head word to TX_FSM with a level handshake: Transmit_Start_Out is held
//   until the synchronised Tx_Busy rises, and the word is popped once
//   Tx_Busy falls again. New launches are gated by CTS and BIST_Mode, but
//   only while idle; a launch in progress always runs to completion.
//
// Optional feature macro: TX_START_TIMEOUT_EN
//   When defined, START gives up after TIMEOUT_CYCLES without a Tx_Busy rise,
//   returns to IDLE without popping and pulses Tx_Timeout for one cycle.
//
// Ports
//   SysClk              system clock, all state on the rising edge
//   Rst                 asynchronous active-low reset
//   Push_Data           write strobe, one word per high cycle
//   Tx_Data_In          word to push
//   Clr_Overflow        clears the sticky FIFO_Overflow flag
//   CTS                 peer ready to receive
//   BIST_Mode           suppresses new launches
//   Tx_Busy             TX_FSM busy (baud domain), synchronised here
//   Tx_Data_Out         registered head word presented to TX_FSM
//   Transmit_Start_Out  launch request to TX_FSM
//   FIFO_Empty          occupancy == 0
//   FIFO_Full           occupancy == depth
//   FIFO_Overflow       sticky: push attempted while full with no pop
//   Tx_Count            current occupancy
//   Tx_Timeout          (optional) one-cycle pulse on START timeout
// ----------------------------------------------------------------------------
module tx_fifo_sequencer #(
   parameter int DATA_BITS      = 8,
   parameter int FIFO_WIDTH     = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  SysClk,
   input  logic                  Rst,
   input  logic                  Push_Data,
   input  logic [DATA_BITS-1:0]  Tx_Data_In,
   input  logic                  Clr_Overflow,
   input  logic                  CTS,
   input  logic                  BIST_Mode,
   input  logic                  Tx_Busy,
   output logic [DATA_BITS-1:0]  Tx_Data_Out,
   output logic                  Transmit_Start_Out,
   output logic                  FIFO_Empty,
   output logic                  FIFO_Full,
   output logic                  FIFO_Overflow,
   output logic [FIFO_WIDTH:0]   Tx_Count
`ifdef TX_START_TIMEOUT_EN
   ,
   output logic                  Tx_Timeout
`endif
);

   localparam int DEPTH = 1 << FIFO_WIDTH;
   localparam logic [FIFO_WIDTH:0] DEPTH_C = {1'b1, {FIFO_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

   state_t                  state, state_nxt;
   logic [DATA_BITS-1:0]    mem [DEPTH];
   logic [FIFO_WIDTH-1:0]   wr_ptr, rd_ptr;
   logic [FIFO_WIDTH:0]     count;
   logic                    busy_s1, busy_s2;
   logic                    launch, pop, push_ok, ovf_evt;

   // Tx_Busy comes from the baud-clock domain
   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) begin
         busy_s1 <= 1'b0;
         busy_s2 <= 1'b0;
      end else begin
         busy_s1 <= Tx_Busy;
         busy_s2 <= busy_s1;
      end
   end

   assign FIFO_Empty = (count == '0);
   assign FIFO_Full  = (count == DEPTH_C);
   assign Tx_Count   = count;

   assign launch  = (state == IDLE) && !FIFO_Empty && CTS && !BIST_Mode && !busy_s2;
   assign pop     = (state == WAIT_DONE) && !busy_s2;
   // A pop frees the slot this same cycle, so a push into a full FIFO is
   // still accepted when it coincides with a pop.
   assign push_ok = Push_Data && (!FIFO_Full || pop);
   assign ovf_evt = Push_Data && FIFO_Full && !pop;

`ifdef TX_START_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        tmo_hit;

   assign tmo_hit = (state == START) && !busy_s2 &&
                    (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) begin
         tmo_cnt    <= '0;
         Tx_Timeout <= 1'b0;
      end else begin
         tmo_cnt    <= (state == START && !tmo_hit) ? tmo_cnt + 16'd1 : '0;
         Tx_Timeout <= tmo_hit;
      end
   end
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (launch) state_nxt = START;
         START: begin
            if (busy_s2) state_nxt = WAIT_DONE;
`ifdef TX_START_TIMEOUT_EN
            else if (tmo_hit) state_nxt = IDLE;
`endif
         end
         WAIT_DONE: if (!busy_s2) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      Transmit_Start_Out = 1'b0;
      if (state == START) Transmit_Start_Out = 1'b1;
   end

   // ---------------- storage ----------------
   always_ff @(posedge SysClk) begin
      if (push_ok) mem[wr_ptr] <= Tx_Data_In;
   end

   always_ff @(posedge SysClk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         FIFO_Overflow <= 1'b0;
         Tx_Data_Out   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + FIFO_WIDTH'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_WIDTH'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (FIFO_WIDTH+1)'(1);
            2'b01:   count <= count - (FIFO_WIDTH+1)'(1);
            default: count <= count;
         endcase
         // overflow event beats a same-cycle clear
         if (ovf_evt)           FIFO_Overflow <= 1'b1;
         else if (Clr_Overflow) FIFO_Overflow <= 1'b0;
         // head word captured on launch, held through START/WAIT_DONE
         if (launch) Tx_Data_Out <= mem[rd_ptr];
      end
   end

endmodule
